// File: rtl/sr_cpu_mc.sv
// sr_cpu_mc: multi-cycle RV32I-subset core, one instruction in flight.
// IDLE -> FETCH -> EXEC [-> MEM] -> FETCH; control outputs are registered.
module sr_cpu_mc #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter bit          WORD_ADDR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        retire,
    output logic        illegal,
    input  logic [4:0]  debug_reg_addr,
    output logic [31:0] debug_reg_data
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, MEM} cpuState;

    cpuState     state;
    logic [31:0] pc, ir;
    logic [31:0] rf [32];

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] rd1, rd2, immI, immS, immB, immU;
    logic [31:0] aluRes, pcNext, rfWd;
    logic        regWrite, badOp, isLoad, isStore, taken, rfWe;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];
    assign immI   = {{20{ir[31]}}, ir[31:20]};
    assign immS   = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign immB   = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign immU   = {ir[31:12], 12'b0};
    assign rd1    = rs1 == 5'd0 ? 32'd0 : rf[rs1];
    assign rd2    = rs2 == 5'd0 ? 32'd0 : rf[rs2];

    always_comb begin
        aluRes   = '0;
        regWrite = 1'b0;
        badOp    = 1'b0;
        isLoad   = 1'b0;
        isStore  = 1'b0;
        taken    = 1'b0;
        case (opcode)
            7'b0110011: begin
                regWrite = 1'b1;
                case ({funct7, funct3})
                    {7'h00, 3'd0}: aluRes = rd1 + rd2;
                    {7'h20, 3'd0}: aluRes = rd1 - rd2;
                    {7'h00, 3'd1}: aluRes = rd1 << rd2[4:0];
                    {7'h00, 3'd2}: aluRes = {31'b0, $signed(rd1) < $signed(rd2)};
                    {7'h00, 3'd3}: aluRes = {31'b0, rd1 < rd2};
                    {7'h00, 3'd4}: aluRes = rd1 ^ rd2;
                    {7'h00, 3'd5}: aluRes = rd1 >> rd2[4:0];
                    {7'h20, 3'd5}: aluRes = $signed(rd1) >>> rd2[4:0];
                    {7'h00, 3'd6}: aluRes = rd1 | rd2;
                    {7'h00, 3'd7}: aluRes = rd1 & rd2;
                    default: begin
                        regWrite = 1'b0;
                        badOp    = 1'b1;
                    end
                endcase
            end
            7'b0010011: begin
                aluRes   = rd1 + immI;
                regWrite = funct3 == 3'd0;
                badOp    = funct3 != 3'd0;
            end
            7'b0110111: begin
                aluRes   = immU;
                regWrite = 1'b1;
            end
            7'b1100011: begin
                badOp = funct3[2:1] != 2'b00;
                taken = !badOp && ((rd1 == rd2) != funct3[0]);
            end
            7'b0000011: begin
                isLoad = funct3 == 3'd2;
                badOp  = !isLoad;
            end
            7'b0100011: begin
                isStore = funct3 == 3'd2;
                badOp   = !isStore;
            end
            default: badOp = 1'b1;
        endcase
    end

    assign pcNext         = pc + (taken ? immB : 32'd4);
    assign imem_addr      = WORD_ADDR ? {2'b00, pc[31:2]} : pc;
    assign debug_reg_data = debug_reg_addr == 5'd0 ? pc : rf[debug_reg_addr];
    // A load writes back only when its data phase completes
    assign rfWe = (state == EXEC && regWrite) || (state == MEM && dmem_ack && !dmem_we);
    assign rfWd = state == MEM ? dmem_rdata : aluRes;

    always_ff @(posedge clk) begin
        if (rfWe && rd != 5'd0)
            rf[rd] <= rfWd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            ir         <= '0;
            illegal    <= 1'b0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            retire     <= 1'b0;
        end else begin
            retire <= 1'b0;
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: if (imem_ack) begin
                    ir       <= imem_rdata;
                    imem_req <= 1'b0;
                    state    <= EXEC;
                end
                EXEC: if (isLoad || isStore) begin
                    dmem_addr  <= rd1 + (isStore ? immS : immI);
                    dmem_wdata <= rd2;
                    dmem_we    <= isStore;
                    dmem_req   <= 1'b1;
                    state      <= MEM;
                end else begin
                    pc       <= pcNext;
                    retire   <= 1'b1;
                    illegal  <= illegal | badOp;
                    imem_req <= 1'b1;
                    state    <= FETCH;
                end
                MEM: if (dmem_ack) begin
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                    pc       <= pc + 32'd4;
                    retire   <= 1'b1;
                    imem_req <= 1'b1;
                    state    <= FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sr_cpu_mc.sv
// tb_sr_cpu_mc: directed + random instruction stream against an ISA-level model.
// A second instance with word addressing runs in lockstep on the same bus.
module tb_sr_cpu_mc;
    localparam logic [31:0] RST_PC = 32'h100;

    logic        clk = 1'b0, rst = 1'b1;
    logic        imem_ack = 1'b0, dmem_ack = 1'b0;
    logic [31:0] imem_rdata = '0, dmem_rdata = '0;
    logic [4:0]  debug_reg_addr = '0;
    logic        imem_req, dmem_req, dmem_we, retire, illegal;
    logic [31:0] imem_addr, dmem_addr, dmem_wdata, debug_reg_data;
    logic        wImemReq, wDmemReq, wDmemWe, wRetire, wIllegal;
    logic [31:0] wImemAddr, wDmemAddr, wDmemWdata, wDebug;

    sr_cpu_mc #(.RESET_PC(RST_PC), .WORD_ADDR(1'b0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .retire(retire), .illegal(illegal),
        .debug_reg_addr(debug_reg_addr), .debug_reg_data(debug_reg_data)
    );

    sr_cpu_mc #(.RESET_PC(RST_PC), .WORD_ADDR(1'b1)) dutW (
        .clk(clk), .rst(rst),
        .imem_req(wImemReq), .imem_addr(wImemAddr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(wDmemReq), .dmem_we(wDmemWe), .dmem_addr(wDmemAddr), .dmem_wdata(wDmemWdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .retire(wRetire), .illegal(wIllegal),
        .debug_reg_addr(debug_reg_addr), .debug_reg_data(wDebug)
    );

    always #5 clk = ~clk;

    // Instruction kinds: 0..9 R-type, then ADDI LUI BEQ BNE LW SW, 16 = unsupported
    localparam int K_ADDI = 10, K_LUI = 11, K_BEQ = 12, K_BNE = 13, K_LW = 14, K_SW = 15, K_BAD = 16;
    logic [6:0]  rF7 [10] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
    logic [2:0]  rF3 [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
    logic [31:0] badTab [8] = '{32'h0000_0000, 32'h0000_6093, 32'h0000_006f, 32'h0220_80b3,
                                32'h0000_4063, 32'h0000_0083, 32'h0000_0023, 32'h0000_0073};

    int          nChecks = 0, nFails = 0;
    logic [31:0] mr [32];
    logic [31:0] mpc;
    logic        mill;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        assert (got === exp) else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic readReg(input logic [4:0] a, output logic [31:0] v);
        debug_reg_addr = a;
        #1;
        v = debug_reg_data;
    endtask

    function automatic logic [31:0] enc(input int k, input logic [4:0] rd, rs1, rs2, input logic [31:0] imm);
        if (k < 10) return {rF7[k], rs2, rs1, rF3[k], rd, 7'h33};
        case (k)
            K_ADDI:  return {imm[11:0], rs1, 3'd0, rd, 7'h13};
            K_LUI:   return {imm[31:12], rd, 7'h37};
            K_BEQ:   return {imm[12], imm[10:5], rs2, rs1, 3'd0, imm[4:1], imm[11], 7'h63};
            K_BNE:   return {imm[12], imm[10:5], rs2, rs1, 3'd1, imm[4:1], imm[11], 7'h63};
            K_LW:    return {imm[11:0], rs1, 3'd2, rd, 7'h03};
            K_SW:    return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
            default: return badTab[rd[2:0]];
        endcase
    endfunction

    // One full instruction: fetch (with iwait stalls), exec, optional mem (dwait stalls).
    // Starts and ends at a falling edge inside a FETCH cycle.
    task automatic run(input int k, input logic [4:0] rd, rs1, rs2, input logic [31:0] imm,
                       input int iwait, input int dwait, input logic [31:0] ldata, input bit abort = 1'b0);
        logic [31:0] a, b, res, npc, v;
        bit          wr, memOp;
        a     = mr[rs1];
        b     = mr[rs2];
        res   = '0;
        wr    = k <= K_LUI || k == K_LW;
        memOp = k == K_LW || k == K_SW;
        npc   = mpc + 32'd4;
        case (k)
            0: res = a + b;
            1: res = a - b;
            2: res = a << b[4:0];
            3: res = {31'b0, $signed(a) < $signed(b)};
            4: res = {31'b0, a < b};
            5: res = a ^ b;
            6: res = a >> b[4:0];
            7: res = $signed(a) >>> b[4:0];
            8: res = a | b;
            9: res = a & b;
            K_ADDI: res = a + imm;
            K_LUI:  res = imm;
            K_BEQ:  if (a == b) npc = mpc + imm;
            K_BNE:  if (a != b) npc = mpc + imm;
            K_LW:   res = ldata;
            default: ;
        endcase
        for (int w = 0; w < iwait; w++) begin
            check("fetch_wait_req", imem_req, 1);
            check("fetch_wait_addr", imem_addr, mpc);
            if (w > 0) check("fetch_wait_retire", retire, 0);
            imem_ack = 1'b0;
            dmem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        if (iwait > 0) check("fetch_wait_retire", retire, 0);
        check("fetch_req", {imem_req, dmem_req}, 2'b10);
        check("fetch_addr", imem_addr, mpc);
        check("fetch_addr_word", wImemAddr, mpc >> 2);
        imem_ack   = 1'b1;
        imem_rdata = enc(k, rd, rs1, rs2, imm);
        dmem_ack   = 1'b0;
        @(negedge clk);
        check("exec_quiet", {imem_req, dmem_req, retire}, 0);
        imem_ack   = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        @(negedge clk);
        if (memOp) begin
            for (int w = 0; w <= dwait; w++) begin
                check("mem_ctrl", {imem_req, dmem_req, dmem_we, retire}, {1'b0, 1'b1, 1'(k == K_SW), 1'b0});
                check("mem_addr", dmem_addr, a + imm);
                check("mem_addr_w", wDmemAddr, a + imm);
                if (k == K_SW) check("mem_wdata", dmem_wdata, b);
                if (abort) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = ~mr[rd];
                    rst        = 1'b1;
                    #1;
                    check("abort_ctrl", {imem_req, dmem_req, dmem_we, retire}, 0);
                    mpc  = RST_PC;
                    mill = 1'b0;
                    @(negedge clk);
                    check("abort_hold", {imem_req, dmem_req, retire, illegal}, 0);
                    return;
                end
                imem_ack   = 1'($urandom_range(0, 1));
                dmem_ack   = w == dwait;
                dmem_rdata = w == dwait ? ldata : $urandom;
                @(negedge clk);
            end
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        if (wr && rd != 5'd0) mr[rd] = res;
        mpc = npc;
        if (k == K_BAD) mill = 1'b1;
        check("retire", {retire, imem_req, dmem_req}, 3'b110);
        check("illegal", illegal, mill);
        check("word_inst", {wRetire, wIllegal, wImemReq, wDmemReq, wDmemWe}, {1'b1, mill, 1'b1, 1'b0, 1'b0});
        readReg(5'd0, v);
        check("pc", v, mpc);
        check("pc_word_inst", wDebug, mpc);
        if (rd != 5'd0) begin
            readReg(rd, v);
            check("reg_rd", v, mr[rd]);
        end
    endtask

    task automatic releaseReset();
        logic [31:0] v;
        rst = 1'b0;
        #1;
        check("idle_quiet", {imem_req, dmem_req, dmem_we, retire, illegal}, 0);
        readReg(5'd0, v);
        check("reset_pc", v, RST_PC);
        @(negedge clk);
        check("first_fetch", {imem_req, retire}, 2'b10);
        check("first_addr_byte", imem_addr, RST_PC);
        check("first_addr_word", wImemAddr, 32'h40);
    endtask

    function automatic logic [31:0] sx12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

    initial begin
        logic [31:0] v, imm;
        int          k;
        foreach (mr[i]) mr[i] = '0;
        mpc  = RST_PC;
        mill = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {imem_req, dmem_req, dmem_we, retire, illegal}, 0);
        releaseReset();
        check("addi_encoding", enc(K_ADDI, 5'd1, 5'd0, 5'd0, 32'd5), 32'h0050_0093);
        check("beq_encoding", enc(K_BEQ, 5'd0, 5'd0, 5'd0, 32'd8), 32'h0000_0463);
        check("sw_encoding", enc(K_SW, 5'd0, 5'd0, 5'd1, 32'd8), 32'h0010_2423);
        check("lw_encoding", enc(K_LW, 5'd2, 5'd0, 5'd0, 32'd8), 32'h0080_2103);
        run(K_BEQ, 5'd0, 5'd0, 5'd0, 32'd8, 0, 0, 0);
        check("beq_taken_pc", mpc, 32'h108);
        run(K_BNE, 5'd0, 5'd0, 5'd0, 32'd8, 0, 0, 0);
        check("bne_not_taken_pc", mpc, 32'h10c);
        run(K_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 0, 0, 0);
        readReg(5'd1, v);
        check("x1_is_5", v, 32'd5);
        run(K_ADDI, 5'd2, 5'd0, 5'd0, 32'd7, 3, 0, 0);
        run(K_SW, 5'd0, 5'd0, 5'd1, 32'd8, 0, 0, 0);
        run(K_LW, 5'd2, 5'd0, 5'd0, 32'd8, 0, 0, 32'd5);
        readReg(5'd2, v);
        check("x2_is_5", v, 32'd5);
        run(K_ADDI, 5'd0, 5'd1, 5'd0, 32'd9, 0, 0, 0);
        readReg(5'd0, v);
        check("x0_write_ignored_pc", v, mpc);
        for (int r = 3; r < 8; r++)
            run(K_ADDI, 5'(r), 5'd0, 5'd0, sx12(12'($urandom)), 0, 0, 0);
        for (int n = 0; n < 200; n++) begin
            k   = $urandom_range(0, K_BAD);
            imm = k == K_LUI ? ($urandom & 32'hFFFF_F000)
                : (k == K_BEQ || k == K_BNE) ? {{19{v[12]}}, v[12:1], 1'b0}
                : sx12(12'($urandom));
            v   = $urandom;
            if (k == K_BEQ || k == K_BNE) imm = {{19{v[12]}}, v[12:1], 1'b0};
            run(k, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                imm, $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
        end
        run(K_BAD, 5'd3, 5'd0, 5'd0, 32'd0, 0, 0, 0);
        check("illegal_sticky", illegal, 1);
        run(K_ADDI, 5'd4, 5'd4, 5'd0, 32'd1, 1, 0, 0);
        check("illegal_still_set", illegal, 1);
        run(K_LW, 5'd5, 5'd0, 5'd0, 32'd16, 0, 2, 32'hDEAD_BEEF, 1'b1);
        dmem_ack = 1'b0;
        releaseReset();
        check("illegal_cleared", illegal, 0);
        readReg(5'd5, v);
        check("aborted_load_no_write", v, mr[5]);
        readReg(5'd1, v);
        check("rf_kept_over_reset", v, mr[1]);
        run(K_ADDI, 5'd6, 5'd1, 5'd0, 32'd3, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/sr_cpu_mc.md
SR_CPU_MC -- requirements
Module: sr_cpu_mc

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: WORD_ADDR, default 1; 1 = imem_addr is pc>>2 (word address); 0 = imem_addr is pc (byte address).
REQ-003 Ports, one per line (name, direction, width, meaning); one clock; reset is asynchronous and active-high:
  clk             input   1   clock, rising edge
  rst             input   1   async active-high reset
  imem_req        output  1   instruction fetch request
  imem_addr       output  32  fetch address, per WORD_ADDR
  imem_ack        input   1   fetch accepted, imem_rdata valid
  imem_rdata      input   32  instruction word
  dmem_req        output  1   data access request
  dmem_we         output  1   1 = store, 0 = load
  dmem_addr       output  32  byte address rs1+imm
  dmem_wdata      output  32  store data (rs2)
  dmem_ack        input   1   data access complete
  dmem_rdata      input   32  load data, valid with dmem_ack
  retire          output  1   one-cycle pulse per completed instruction
  illegal         output  1   sticky flag, unsupported opcode seen
  debug_reg_addr  input   5   debug register select
  debug_reg_data  output  32  rf[debug_reg_addr]; pc when addr==0

Function
REQ-004 Multi-cycle FSM with states IDLE, FETCH, EXEC, MEM; exactly one instruction in flight.
REQ-005 IDLE: entered on reset; unconditionally -> FETCH next clock.
REQ-006 FETCH: imem_req=1, imem_addr derived from pc; on imem_ack, latch imem_rdata into IR, -> EXEC; no ack -> stay, imem_addr held stable.
REQ-007 EXEC: decode IR with the existing decode/control/ALU; ALU ops, ADDI, LUI, BEQ, BNE complete here: RF write if enabled, pc update, retire=1, -> FETCH.
REQ-008 EXEC with LW (opcode 0000011, f3 010) or SW (opcode 0100011, f3 010): latch address rs1+sign-extended imm and store data, -> MEM; no retire.
REQ-009 MEM: dmem_req=1, dmem_we/addr/wdata held stable; on dmem_ack: LW writes dmem_rdata to rd, pc+=4, retire=1, -> FETCH; no ack -> stay.
REQ-010 Branch: taken -> pc = pc + immB; otherwise, and all non-branch instructions, pc = pc + 4; 32-bit wrap-around, no exception.
REQ-011 Unsupported opcode/funct in EXEC: no RF write, pc+=4, retire=1, illegal set to 1 and held until reset.
REQ-012 Writes to x0 discarded; x0 always reads 0.
REQ-013 imem_ack outside FETCH and dmem_ack outside MEM are ignored; ack may arrive in the same cycle req rises (zero-wait).
REQ-014 Latency with zero-wait memory: ALU/branch = 2 cycles (FETCH, EXEC); LW/SW = 3 cycles (FETCH, EXEC, MEM).
REQ-015 imem_req and dmem_req never high simultaneously.
REQ-016 debug_reg_data is combinational; addr==0 returns pc of current instruction.

Reset
REQ-017 rst asserted: state=IDLE, pc=RESET_PC, IR=0, illegal=0 immediately (asynchronous); imem_req, dmem_req, dmem_we, retire = 0 while rst is high.
REQ-018 Register file contents are not reset.
REQ-019 Reset mid-FETCH or mid-MEM aborts the access: req drops in the same cycle, the pending ack is ignored, no RF write, no retire.
REQ-020 First imem_req occurs in the second rising edge cycle after rst deasserts (IDLE then FETCH).

Verification
REQ-021 RESET_PC=32'h100, WORD_ADDR=0: release rst -> one IDLE cycle, then imem_req=1 with imem_addr=32'h100; with WORD_ADDR=1 -> imem_addr=32'h40.
REQ-022 Zero-wait fetch of 32'h00500093 (addi x1,x0,5) -> retire pulses 2 cycles after FETCH entry; debug_reg_addr=1 reads 5; pc advances by 4.
REQ-023 imem_ack withheld 3 cycles -> imem_req stays 1, imem_addr stable, retire stays 0, pc unchanged until ack.
REQ-024 x1=5; fetch 32'h00102423 (sw x1,8(x0)) -> dmem_req=1, dmem_we=1, dmem_addr=8, dmem_wdata=5; fetch 32'h00802103 (lw x2,8(x0)) with dmem_rdata=5 -> x2=5, retire once per instruction.
REQ-025 At pc=32'h100, fetch 32'h00000463 (beq x0,x0,+8) -> next imem_addr byte value 32'h108; bne x0,x0,+8 -> 32'h104.
REQ-026 Assert rst while in MEM awaiting dmem_ack -> dmem_req=0 the same cycle; after release, fetch restarts at RESET_PC, illegal=0, no retire from the aborted load.
